// File: rtl/wb_arbiter_if.sv
// Result-source and register-file write bus seen by wb_arbiter.
// The slave modport is the arbiter's view; master is the traffic side.
interface wb_arbiter_if #(
  parameter int NUM_SRC    = 4,
  parameter int NUM_REG    = 8,
  parameter int REG_BIT    = 16,
  parameter int NUM_W_PORT = 2,
  parameter int FIFO_DEPTH = 2
);
  localparam int REG_ID_BIT = $clog2(NUM_REG);
  localparam int CNT_BIT    = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_SRC-1:0]               src_vld;
  logic [NUM_SRC-1:0]               src_rdy;
  logic [NUM_SRC*REG_ID_BIT-1:0]    src_addr;
  logic [NUM_SRC*REG_BIT-1:0]       src_data;
  logic [NUM_W_PORT-1:0]            wr_vld;
  logic [NUM_W_PORT-1:0]            wr_rdy;
  logic [NUM_W_PORT*REG_ID_BIT-1:0] wr_addr;
  logic [NUM_W_PORT*REG_BIT-1:0]    wr_data;
  logic [NUM_SRC*CNT_BIT-1:0]       fifo_cnt;

  modport slave (
    input  src_vld, src_addr, src_data, wr_rdy,
    output src_rdy, wr_vld, wr_addr, wr_data, fifo_cnt
  );

  modport master (
    output src_vld, src_addr, src_data, wr_rdy,
    input  src_rdy, wr_vld, wr_addr, wr_data, fifo_cnt
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: per-source FIFOs, round-robin grant onto NUM_W_PORT write ports, 1-cycle latency.
// src_rdy drops when a FIFO is full; WB_DROP_R0_EN discards accepted writes to register 0.
module wb_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int NUM_REG    = 8,
  parameter int REG_BIT    = 16,
  parameter int NUM_W_PORT = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_arbiter_if.slave   bus
);
  localparam int REG_ID_BIT = $clog2(NUM_REG);
  localparam int PTR_BIT    = $clog2(FIFO_DEPTH);
  localparam int CNT_BIT    = PTR_BIT + 1;
  localparam int SRC_BIT    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef struct packed {
    logic [REG_ID_BIT-1:0] addr;
    logic [REG_BIT-1:0]    data;
  } ent_t;

  ent_t                  mem_q  [NUM_SRC][FIFO_DEPTH];
  logic [PTR_BIT-1:0]    wptr_q [NUM_SRC];
  logic [PTR_BIT-1:0]    rptr_q [NUM_SRC];
  logic [CNT_BIT-1:0]    cnt_q  [NUM_SRC];
  logic [SRC_BIT-1:0]    rr_q, rr_d;

  ent_t                  in_ent [NUM_SRC];
  ent_t                  head   [NUM_SRC];
  logic [NUM_SRC-1:0]    full, enq, pop;

  logic [NUM_W_PORT-1:0] wr_vld;
  logic [REG_ID_BIT-1:0] wr_addr_a [NUM_W_PORT];
  logic [REG_BIT-1:0]    wr_data_a [NUM_W_PORT];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign in_ent[i].addr = bus.src_addr[i*REG_ID_BIT +: REG_ID_BIT];
    assign in_ent[i].data = bus.src_data[i*REG_BIT +: REG_BIT];
    assign head[i]        = mem_q[i][rptr_q[i]];
    assign full[i]        = (cnt_q[i] == CNT_BIT'(FIFO_DEPTH));
    // Ready depends on occupancy only, so a same-cycle pop never lets a full FIFO accept.
    assign bus.src_rdy[i] = !full[i];
`ifdef WB_DROP_R0_EN
    assign enq[i] = bus.src_vld[i] && !full[i] && (in_ent[i].addr != '0);
`else
    assign enq[i] = bus.src_vld[i] && !full[i];
`endif
    assign bus.fifo_cnt[i*CNT_BIT +: CNT_BIT] = cnt_q[i];
  end

  for (genvar p = 0; p < NUM_W_PORT; p++) begin : g_port
    assign bus.wr_addr[p*REG_ID_BIT +: REG_ID_BIT] = wr_addr_a[p];
    assign bus.wr_data[p*REG_BIT +: REG_BIT]       = wr_data_a[p];
  end
  assign bus.wr_vld = wr_vld;

  // Scan from rr_q; each non-empty head takes the next free port unless an
  // earlier grant this cycle already targets the same register.
  always_comb begin
    int   np;
    int   s;
    int   nxt;
    logic clash;
    wr_vld = '0;
    pop    = '0;
    rr_d   = rr_q;
    np     = 0;
    s      = 0;
    nxt    = 0;
    clash  = 1'b0;
    for (int p = 0; p < NUM_W_PORT; p++) begin
      wr_addr_a[p] = '0;
      wr_data_a[p] = '0;
    end
    for (int j = 0; j < NUM_SRC; j++) begin
      s = int'(rr_q) + j;
      if (s >= NUM_SRC) s = s - NUM_SRC;
      clash = 1'b0;
      for (int p = 0; p < NUM_W_PORT; p++) begin
        if (p < np && wr_addr_a[p] == head[s].addr) clash = 1'b1;
      end
      if (cnt_q[s] != '0 && np < NUM_W_PORT && !clash) begin
        wr_vld[np]    = 1'b1;
        wr_addr_a[np] = head[s].addr;
        wr_data_a[np] = head[s].data;
        if (bus.wr_rdy[np]) begin
          pop[s] = 1'b1;
          nxt    = (s + 1 == NUM_SRC) ? 0 : s + 1;
          rr_d   = SRC_BIT'(nxt);
        end
        np = np + 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (enq[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
        if (pop[i]) rptr_q[i] <= rptr_q[i] + 1'b1;
        case ({enq[i], pop[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + 1'b1;
          2'b01:   cnt_q[i] <= cnt_q[i] - 1'b1;
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (enq[i]) mem_q[i][wptr_q[i]] <= in_ent[i];
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a per-cycle vector table plus reset, backpressure and r0 sequences.
module tb_wb_arbiter;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  wb_arbiter_if #(.NUM_SRC(4), .NUM_REG(8), .REG_BIT(16), .NUM_W_PORT(2), .FIFO_DEPTH(2)) bus ();

  wb_arbiter #(.NUM_SRC(4), .NUM_REG(8), .REG_BIT(16), .NUM_W_PORT(2), .FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vld;
    logic [11:0] addr;
    logic [63:0] data;
    logic [1:0]  rdy;
    logic [1:0]  e_vld;
    logic [5:0]  e_addr;
    logic [31:0] e_data;
    logic [3:0]  e_rdy;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are read 1ns later.
  task automatic drive(input logic [3:0] v, input logic [11:0] a, input logic [63:0] d, input logic [1:0] r);
    @(negedge clk);
    bus.src_vld  = v;
    bus.src_addr = a;
    bus.src_data = d;
    bus.wr_rdy   = r;
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.src_vld  = '0;
    bus.src_addr = '0;
    bus.src_data = '0;
    bus.wr_rdy   = '0;

    //          vld      addr     data                    rdy    e_vld  e_addr e_data          e_rdy  e_cnt
    tbl[0]  = '{4'b0001, 12'h003, 64'h0000_0000_0000_1234, 2'b11, 2'b00, 6'h00, 32'h0000_0000, 4'hF, 8'h00};
    tbl[1]  = '{4'b0000, 12'h000, 64'h0,                   2'b11, 2'b01, 6'h03, 32'h0000_1234, 4'hF, 8'h01};
    tbl[2]  = '{4'b1000, 12'hE00, 64'hAAAA_0000_0000_0000, 2'b11, 2'b00, 6'h00, 32'h0000_0000, 4'hF, 8'h00};
    tbl[3]  = '{4'b0000, 12'h000, 64'h0,                   2'b11, 2'b01, 6'h07, 32'h0000_AAAA, 4'hF, 8'h40};
    tbl[4]  = '{4'b1111, 12'h8D1, 64'h1003_1002_1001_1000, 2'b11, 2'b00, 6'h00, 32'h0000_0000, 4'hF, 8'h00};
    tbl[5]  = '{4'b0000, 12'h000, 64'h0,                   2'b11, 2'b11, 6'h11, 32'h1001_1000, 4'hF, 8'h55};
    tbl[6]  = '{4'b0000, 12'h000, 64'h0,                   2'b11, 2'b11, 6'h23, 32'h1003_1002, 4'hF, 8'h50};
    tbl[7]  = '{4'b0011, 12'h02D, 64'h0000_0000_B1B1_B0B0, 2'b11, 2'b00, 6'h00, 32'h0000_0000, 4'hF, 8'h00};
    tbl[8]  = '{4'b0000, 12'h000, 64'h0,                   2'b11, 2'b01, 6'h05, 32'h0000_B0B0, 4'hF, 8'h05};
    tbl[9]  = '{4'b0000, 12'h000, 64'h0,                   2'b11, 2'b01, 6'h05, 32'h0000_B1B1, 4'hF, 8'h04};
    tbl[10] = '{4'b1101, 12'hC81, 64'hC3C3_C2C2_0000_C0C0, 2'b11, 2'b00, 6'h00, 32'h0000_0000, 4'hF, 8'h00};
    tbl[11] = '{4'b0000, 12'h000, 64'h0,                   2'b01, 2'b11, 6'h32, 32'hC3C3_C2C2, 4'hF, 8'h51};
    tbl[12] = '{4'b0000, 12'h000, 64'h0,                   2'b11, 2'b11, 6'h0E, 32'hC0C0_C3C3, 4'hF, 8'h41};
    tbl[13] = '{4'b0000, 12'h000, 64'h0,                   2'b11, 2'b00, 6'h00, 32'h0000_0000, 4'hF, 8'h00};

    #2;
    check("rst_wr_vld",  64'(bus.wr_vld),   64'h0);
    check("rst_src_rdy", 64'(bus.src_rdy),  64'hF);
    check("rst_cnt",     64'(bus.fifo_cnt), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].vld, tbl[i].addr, tbl[i].data, tbl[i].rdy);
      check($sformatf("v%0d_wr_vld", i),  64'(bus.wr_vld),   64'(tbl[i].e_vld));
      check($sformatf("v%0d_wr_addr", i), 64'(bus.wr_addr),  64'(tbl[i].e_addr));
      check($sformatf("v%0d_wr_data", i), 64'(bus.wr_data),  64'(tbl[i].e_data));
      check($sformatf("v%0d_src_rdy", i), 64'(bus.src_rdy),  64'(tbl[i].e_rdy));
      check($sformatf("v%0d_cnt", i),     64'(bus.fifo_cnt), 64'(tbl[i].e_cnt));
    end

    // src2 pushes every cycle while the write ports stall for four cycles.
    drive(4'b0100, 12'h080, 64'h0000_D001_0000_0000, 2'b00);
    check("bp_c1_rdy", 64'(bus.src_rdy), 64'hF);
    drive(4'b0100, 12'h080, 64'h0000_D002_0000_0000, 2'b00);
    check("bp_c2_rdy", 64'(bus.src_rdy), 64'hF);
    check("bp_c2_vld", 64'(bus.wr_vld),  64'h1);
    drive(4'b0100, 12'h080, 64'h0000_D003_0000_0000, 2'b00);
    check("bp_c3_rdy", 64'(bus.src_rdy),  64'hB);
    check("bp_c3_cnt", 64'(bus.fifo_cnt), 64'h20);
    drive(4'b0100, 12'h080, 64'h0000_D003_0000_0000, 2'b00);
    check("bp_c4_rdy", 64'(bus.src_rdy),  64'hB);
    check("bp_c4_cnt", 64'(bus.fifo_cnt), 64'h20);
    drive(4'b0100, 12'h080, 64'h0000_D003_0000_0000, 2'b11);
    check("bp_c5_rdy",  64'(bus.src_rdy), 64'hB);
    check("bp_c5_vld",  64'(bus.wr_vld),  64'h1);
    check("bp_c5_data", 64'(bus.wr_data), 64'h0000_D001);
    drive(4'b0000, 12'h000, 64'h0, 2'b11);
    check("bp_c6_data", 64'(bus.wr_data),  64'h0000_D002);
    check("bp_c6_cnt",  64'(bus.fifo_cnt), 64'h10);
    check("bp_c6_rdy",  64'(bus.src_rdy),  64'hF);
    drive(4'b0000, 12'h000, 64'h0, 2'b11);
    check("bp_c7_vld", 64'(bus.wr_vld),   64'h0);
    check("bp_c7_cnt", 64'(bus.fifo_cnt), 64'h0);

    // Write to register 0.
    drive(4'b0001, 12'h000, 64'h0000_0000_0000_0E0E, 2'b11);
    check("r0_rdy", 64'(bus.src_rdy), 64'hF);
    drive(4'b0000, 12'h000, 64'h0, 2'b11);
`ifdef WB_DROP_R0_EN
    check("r0_vld", 64'(bus.wr_vld),   64'h0);
    check("r0_cnt", 64'(bus.fifo_cnt), 64'h0);
`else
    check("r0_vld",  64'(bus.wr_vld),   64'h1);
    check("r0_addr", 64'(bus.wr_addr),  64'h0);
    check("r0_data", 64'(bus.wr_data),  64'h0000_0E0E);
    check("r0_cnt",  64'(bus.fifo_cnt), 64'h01);
`endif

    // Asynchronous reset with three entries queued.
    drive(4'b1011, 12'h811, 64'h00E3_0000_00E1_00E0, 2'b00);
    drive(4'b0000, 12'h000, 64'h0, 2'b00);
    check("mr_cnt_pre", 64'(bus.fifo_cnt), 64'h45);
    check("mr_vld_pre", 64'(bus.wr_vld),   64'h3);
    rst_n = 1'b0;
    #1;
    check("mr_cnt_async", 64'(bus.fifo_cnt), 64'h0);
    check("mr_vld_async", 64'(bus.wr_vld),   64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0000, 12'h000, 64'h0, 2'b11);
    check("mr_vld", 64'(bus.wr_vld),   64'h0);
    check("mr_cnt", 64'(bus.fifo_cnt), 64'h0);
    check("mr_rdy", 64'(bus.src_rdy),  64'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
